// File: rtl/mac_pkg.sv
// Shared helpers for the dot-product MAC: accumulator sizing and saturation bounds.
package mac_pkg;

   // Saturation bounds are built at a fixed width and sliced down by the user.
   localparam int SAT_BITS = 256;

   function automatic int acc_width(input int width, input int guard);
      return 2 * width + guard;
   endfunction

   function automatic logic [SAT_BITS-1:0] sat_max(input int acc_w, input bit is_signed);
      logic [SAT_BITS-1:0] ones;
      ones = '1;
      return is_signed ? (ones >> (SAT_BITS - acc_w + 1)) : (ones >> (SAT_BITS - acc_w));
   endfunction

   function automatic logic [SAT_BITS-1:0] sat_min(input int acc_w, input bit is_signed);
      logic [SAT_BITS-1:0] one;
      one = 1;
      return is_signed ? (one << (acc_w - 1)) : '0;
   endfunction

endpackage

// File: rtl/mac_dot_pipe_if.sv
// Operand stream in, completed dot product out; master drives operands, slave is the MAC.
interface mac_dot_pipe_if #(
   parameter int WIDTH = 64,
   parameter int GUARD = 8
);
   import mac_pkg::*;

   localparam int ACC_WIDTH = acc_width(WIDTH, GUARD);

   logic                 in_valid;
   logic                 in_ready;
   logic                 in_last;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [ACC_WIDTH-1:0] accumulator;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_WIDTH-1:0] out_result;
   logic                 out_overflow;

   modport master (
      output in_valid, in_last, a, b, out_ready,
      input  in_ready, accumulator, out_valid, out_result, out_overflow
   );

   modport slave (
      input  in_valid, in_last, a, b, out_ready,
      output in_ready, accumulator, out_valid, out_result, out_overflow
   );

endinterface

// File: rtl/mac_mul_pipe.sv
// Multiplier with MUL_STAGES register stages; valid/last travel with the product and
// every stage holds while i_en is low.
module mac_mul_pipe #(
   parameter int WIDTH      = 64,
   parameter bit SIGNED     = 1'b0,
   parameter int MUL_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_en,
   input  logic                 i_valid,
   input  logic                 i_last,
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   output logic                 o_valid,
   output logic                 o_last,
   output logic [2*WIDTH-1:0]   o_prod
);
   logic [2*WIDTH-1:0] w_prod;

   // Operands are widened to the product width first so the multiply is full precision.
   generate
      if (SIGNED) begin : g_smul
         logic signed [2*WIDTH-1:0] w_sprod;
         assign w_sprod = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) * $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});
         assign w_prod  = w_sprod;
      end else begin : g_umul
         assign w_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
      end

      if (MUL_STAGES == 0) begin : g_comb
         assign o_valid = i_valid;
         assign o_last  = i_last;
         assign o_prod  = w_prod;
      end else begin : g_pipe
         for (genvar gi = 0; gi < MUL_STAGES; gi++) begin : g_stage
            logic               r_valid;
            logic               r_last;
            logic [2*WIDTH-1:0] r_prod;
            logic               w_valid_in;
            logic               w_last_in;
            logic [2*WIDTH-1:0] w_prod_in;

            if (gi == 0) begin : g_src
               assign w_valid_in = i_valid;
               assign w_last_in  = i_last;
               assign w_prod_in  = w_prod;
            end else begin : g_src
               assign w_valid_in = g_stage[gi-1].r_valid;
               assign w_last_in  = g_stage[gi-1].r_last;
               assign w_prod_in  = g_stage[gi-1].r_prod;
            end

            always_ff @(posedge clk) begin
               if (reset) begin
                  r_valid <= 1'b0;
               end else if (i_en) begin
                  r_valid <= w_valid_in;
               end
               if (i_en) begin
                  r_last <= w_last_in;
                  r_prod <= w_prod_in;
               end
            end
         end

         assign o_valid = g_stage[MUL_STAGES-1].r_valid;
         assign o_last  = g_stage[MUL_STAGES-1].r_last;
         assign o_prod  = g_stage[MUL_STAGES-1].r_prod;
      end
   endgenerate

endmodule

// File: rtl/mac_dot_pipe.sv
// Pipelined dot-product MAC: saturating accumulate stage, sticky overflow per vector and
// a one-deep result register whose back-pressure freezes the whole pipe.
module mac_dot_pipe
   import mac_pkg::*;
#(
   parameter int WIDTH      = 64,
   parameter int GUARD      = 8,
   parameter int MUL_STAGES = 2,
   parameter bit SIGNED     = 1'b0
) (
   input  logic          clk,
   input  logic          reset,
   mac_dot_pipe_if.slave bus
);
   localparam int                    ACC_WIDTH    = acc_width(WIDTH, GUARD);
   localparam int                    MSB          = ACC_WIDTH - 1;
   localparam logic [SAT_BITS-1:0]   SAT_MAX_FULL = sat_max(ACC_WIDTH, SIGNED);
   localparam logic [SAT_BITS-1:0]   SAT_MIN_FULL = sat_min(ACC_WIDTH, SIGNED);
   localparam logic [ACC_WIDTH-1:0]  SAT_MAX      = SAT_MAX_FULL[ACC_WIDTH-1:0];
   localparam logic [ACC_WIDTH-1:0]  SAT_MIN      = SAT_MIN_FULL[ACC_WIDTH-1:0];

   logic                 w_stall;
   logic                 w_en;
   logic                 w_p_valid;
   logic                 w_p_last;
   logic [2*WIDTH-1:0]   w_prod;
   logic [ACC_WIDTH-1:0] w_prod_ext;
   logic [ACC_WIDTH:0]   w_sum;
   logic [ACC_WIDTH-1:0] w_sat;
   logic                 w_ovf;
   logic                 w_fire;

   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_sticky;
   logic                 r_out_valid;
   logic [ACC_WIDTH-1:0] r_result;
   logic                 r_out_ovf;

   assign w_stall      = r_out_valid & ~bus.out_ready;
   assign w_en         = ~w_stall;
   assign bus.in_ready = w_en;

   mac_mul_pipe #(
      .WIDTH      (WIDTH),
      .SIGNED     (SIGNED),
      .MUL_STAGES (MUL_STAGES)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .i_en    (w_en),
      .i_valid (bus.in_valid),
      .i_last  (bus.in_last),
      .i_a     (bus.a),
      .i_b     (bus.b),
      .o_valid (w_p_valid),
      .o_last  (w_p_last),
      .o_prod  (w_prod)
   );

   generate
      if (SIGNED) begin : g_sext
         assign w_prod_ext = ACC_WIDTH'($signed(w_prod));
      end else begin : g_zext
         assign w_prod_ext = ACC_WIDTH'(w_prod);
      end
   endgenerate

   assign w_sum  = {1'b0, r_acc} + {1'b0, w_prod_ext};
   assign w_fire = w_p_valid & w_en;

   // Signed overflow: both addends share a sign that the sum lost; clamp toward that sign.
   always_comb begin
      w_ovf = 1'b0;
      w_sat = w_sum[ACC_WIDTH-1:0];
      if (SIGNED) begin
         if ((r_acc[MSB] == w_prod_ext[MSB]) && (w_sum[MSB] != r_acc[MSB])) begin
            w_ovf = 1'b1;
            w_sat = r_acc[MSB] ? SAT_MIN : SAT_MAX;
         end
      end else if (w_sum[ACC_WIDTH]) begin
         w_ovf = 1'b1;
         w_sat = SAT_MAX;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc       <= '0;
         r_sticky    <= 1'b0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_out_ovf   <= 1'b0;
      end else begin
         if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_fire) begin
            if (w_p_last) begin
               r_result    <= w_sat;
               r_out_ovf   <= r_sticky | w_ovf;
               r_out_valid <= 1'b1;
               r_acc       <= '0;
               r_sticky    <= 1'b0;
            end else begin
               r_acc       <= w_sat;
               r_sticky    <= r_sticky | w_ovf;
            end
         end
      end
   end

   assign bus.accumulator  = r_acc;
   assign bus.out_valid    = r_out_valid;
   assign bus.out_result   = r_result;
   assign bus.out_overflow = r_out_ovf;

endmodule

// File: tb/tb_mac_dot_pipe.sv
// Scoreboard bench for mac_dot_pipe: three configurations (64-bit unsigned, 8-bit unsigned
// with no guard bits, 8-bit signed combinational multiplier) against an integer model.
module tb_mac_dot_pipe;
   import mac_pkg::*;

   typedef struct {
      logic [135:0] res;
      bit           ovf;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int cfg_w    [3] = '{64, 8, 8};
   int cfg_accw [3] = '{136, 16, 16};
   bit cfg_sgn  [3] = '{1'b0, 1'b0, 1'b1};

   logic        d_valid [3];
   logic        d_last  [3];
   logic        d_ready [3];
   logic [63:0] d_a     [3];
   logic [63:0] d_b     [3];

   logic         m_rdy   [3];
   logic         m_valid [3];
   logic         m_ov    [3];
   logic [135:0] m_acc   [3];
   logic [135:0] m_res   [3];

   mac_dot_pipe_if #(.WIDTH(64), .GUARD(8)) if0 ();
   mac_dot_pipe_if #(.WIDTH(8),  .GUARD(0)) if1 ();
   mac_dot_pipe_if #(.WIDTH(8),  .GUARD(0)) if2 ();

   mac_dot_pipe #(.WIDTH(64), .GUARD(8), .MUL_STAGES(2), .SIGNED(1'b0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
   mac_dot_pipe #(.WIDTH(8),  .GUARD(0), .MUL_STAGES(1), .SIGNED(1'b0)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
   mac_dot_pipe #(.WIDTH(8),  .GUARD(0), .MUL_STAGES(0), .SIGNED(1'b1)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));

   assign if0.in_valid = d_valid[0];
   assign if0.in_last  = d_last[0];
   assign if0.a        = d_a[0];
   assign if0.b        = d_b[0];
   assign if0.out_ready = d_ready[0];
   assign if1.in_valid = d_valid[1];
   assign if1.in_last  = d_last[1];
   assign if1.a        = d_a[1][7:0];
   assign if1.b        = d_b[1][7:0];
   assign if1.out_ready = d_ready[1];
   assign if2.in_valid = d_valid[2];
   assign if2.in_last  = d_last[2];
   assign if2.a        = d_a[2][7:0];
   assign if2.b        = d_b[2][7:0];
   assign if2.out_ready = d_ready[2];

   assign m_rdy[0]   = if0.in_ready;
   assign m_rdy[1]   = if1.in_ready;
   assign m_rdy[2]   = if2.in_ready;
   assign m_valid[0] = if0.out_valid;
   assign m_valid[1] = if1.out_valid;
   assign m_valid[2] = if2.out_valid;
   assign m_ov[0]    = if0.out_overflow;
   assign m_ov[1]    = if1.out_overflow;
   assign m_ov[2]    = if2.out_overflow;
   assign m_acc[0]   = if0.accumulator;
   assign m_acc[1]   = 136'(if1.accumulator);
   assign m_acc[2]   = 136'(if2.accumulator);
   assign m_res[0]   = if0.out_result;
   assign m_res[1]   = 136'(if1.out_result);
   assign m_res[2]   = 136'(if2.out_result);

   // ---------------- reference model: integer dot product with clamping ----------------
   exp_t                q0[$], q1[$], q2[$];
   logic signed [199:0] mdl_acc    [3];
   bit                  mdl_sticky [3];

   function automatic logic signed [199:0] ext(input logic [63:0] v, input int k);
      logic signed [199:0] r;
      r = {136'b0, v};
      if (cfg_sgn[k] && v[cfg_w[k]-1]) r = r - (200'sd1 <<< cfg_w[k]);
      return r;
   endfunction

   function automatic logic signed [199:0] sat(input logic signed [199:0] s, input int k, output bit ov);
      logic signed [199:0] one, hi, lo;
      one = 1;
      if (cfg_sgn[k]) begin
         hi = (one <<< (cfg_accw[k] - 1)) - one;
         lo = -(one <<< (cfg_accw[k] - 1));
      end else begin
         hi = (one <<< cfg_accw[k]) - one;
         lo = 0;
      end
      ov = 1'b0;
      if (s > hi) begin
         ov = 1'b1;
         return hi;
      end
      if (s < lo) begin
         ov = 1'b1;
         return lo;
      end
      return s;
   endfunction

   function automatic logic [135:0] acc_mask(input int k);
      logic [136:0] one;
      one = 1;
      return 136'((one << cfg_accw[k]) - one);
   endfunction

   task automatic push_exp(input int k, input exp_t e);
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic pop_exp(input int k, output exp_t e, output bit have);
      have = 1'b0;
      e.res = '0;
      e.ovf = 1'b0;
      case (k)
         0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
   endtask

   task automatic model_accept(input int k, input logic [63:0] a, input logic [63:0] b, input bit last);
      logic signed [199:0] s;
      bit                  ov;
      exp_t                e;
      s = sat(mdl_acc[k] + ext(a, k) * ext(b, k), k, ov);
      if (last) begin
         e.res = s[135:0] & acc_mask(k);
         e.ovf = mdl_sticky[k] | ov;
         push_exp(k, e);
         mdl_acc[k]    = 0;
         mdl_sticky[k] = 1'b0;
      end else begin
         mdl_acc[k]    = s;
         mdl_sticky[k] = mdl_sticky[k] | ov;
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mdl_acc[k]    = 0;
         mdl_sticky[k] = 1'b0;
      end
      q0.delete();
      q1.delete();
      q2.delete();
   endtask

   // ---------------- driver ----------------
   task automatic chk(input string name, input logic [135:0] act, input logic [135:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic send(input int k, input logic [63:0] a, input logic [63:0] b, input bit last);
      bit ok;
      int waited;
      d_valid[k] = 1'b1;
      d_a[k]     = a;
      d_b[k]     = b;
      d_last[k]  = last;
      waited     = 0;
      do begin
         @(negedge clk);
         ok = m_rdy[k];
         @(posedge clk);
         waited++;
      end while (!ok && waited < 200);
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_timeout inst=%0d actual=in_ready_low required=accept_within_200", k);
      end else begin
         model_accept(k, a, b, last);
         $display("beat inst=%0d a=%0h b=%0h last=%0d", k, a, b, last);
      end
      #1;
      d_valid[k] = 1'b0;
      d_last[k]  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rand_stream(input int k, input int n);
      logic [63:0] a, b;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         if (k == 0) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
         end else begin
            a = 64'($urandom_range(0, 255));
            b = 64'($urandom_range(0, 255));
         end
         send(k, a, b, (i == n - 1) || ($urandom_range(0, 3) == 0));
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!reset && m_valid[k] && d_ready[k]) begin
            exp_t e;
            bit   have;
            pop_exp(k, e, have);
            checks++;
            if (!have) begin
               failures++;
               $display("FAIL result_unexpected inst=%0d actual=%0h required=no_result", k, m_res[k]);
            end else if (m_res[k] !== e.res || m_ov[k] !== e.ovf) begin
               failures++;
               $display("FAIL result inst=%0d actual=%0h ovf=%0d required=%0h ovf=%0d",
                        k, m_res[k], m_ov[k], e.res, e.ovf);
            end else begin
               $display("result inst=%0d value=%0h ovf=%0d", k, m_res[k], m_ov[k]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=still_running required=finished");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   bit rnd_done;

   initial begin
      for (int k = 0; k < 3; k++) begin
         d_valid[k] = 1'b0;
         d_last[k]  = 1'b0;
         d_ready[k] = 1'b1;
         d_a[k]     = '0;
         d_b[k]     = '0;
      end
      model_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset_acc%0d", k),   m_acc[k], 136'd0);
         chk($sformatf("reset_valid%0d", k), 136'(m_valid[k]), 136'd0);
         chk($sformatf("reset_res%0d", k),   m_res[k], 136'd0);
         chk($sformatf("reset_ready%0d", k), 136'(m_rdy[k]), 136'd1);
      end
      idle(1);

      // Basic vector with two-edge multiplier latency.
      send(0, 64'd2, 64'd3, 1'b0);
      send(0, 64'd7, 64'd3, 1'b1);
      @(negedge clk);
      chk("basic_acc_early", m_acc[0], 136'd0);
      @(negedge clk);
      chk("basic_acc_partial", m_acc[0], 136'd6);
      @(negedge clk);
      chk("basic_out_valid", 136'(m_valid[0]), 136'd1);
      chk("basic_acc_cleared", m_acc[0], 136'd0);
      idle(4);

      // Back-pressure: result held, pipe frozen, nothing lost.
      d_ready[0] = 1'b0;
      send(0, 64'd13, 64'd4, 1'b0);
      send(0, 64'd7,  64'd3, 1'b1);
      send(0, 64'd3,  64'd6, 1'b1);
      repeat (4) @(negedge clk);
      chk("bp_in_ready", 136'(m_rdy[0]), 136'd0);
      chk("bp_valid_held", 136'(m_valid[0]), 136'd1);
      chk("bp_result_held", m_res[0], 136'd73);
      @(posedge clk);
      #1;
      d_ready[0] = 1'b1;
      idle(6);
      chk("bp_drained", 136'(q0.size()), 136'd0);

      // Wide operands.
      send(0, 64'd15475927394819283748, 64'd12002991839102938298, 1'b1);
      idle(5);

      // Unsigned saturation without guard bits, then a clean vector.
      send(1, 64'd255, 64'd255, 1'b0);
      send(1, 64'd255, 64'd255, 1'b1);
      send(1, 64'd1,   64'd1,   1'b1);
      idle(4);

      // Signed: (-3*5) + (2*4) = -7.
      send(2, 64'hFD, 64'd5, 1'b0);
      send(2, 64'd2,  64'd4, 1'b1);
      idle(4);

      // Reset mid-vector discards the in-flight beat.
      send(0, 64'd10, 64'd5, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("midreset_no_valid", 136'(m_valid[0]), 136'd0);
         chk("midreset_acc", m_acc[0], 136'd0);
      end
      idle(1);
      send(0, 64'd14, 64'd2, 1'b1);
      idle(5);

      // Randomized traffic with random back-pressure on all three configurations.
      rnd_done = 1'b0;
      fork
         begin
            fork
               rand_stream(0, 120);
               rand_stream(1, 120);
               rand_stream(2, 120);
            join
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               for (int k = 0; k < 3; k++) d_ready[k] = ($urandom_range(0, 3) != 0);
            end
         end
      join
      for (int k = 0; k < 3; k++) d_ready[k] = 1'b1;
      idle(20);
      chk("final_q0_empty", 136'(q0.size()), 136'd0);
      chk("final_q1_empty", 136'(q1.size()), 136'd0);
      chk("final_q2_empty", 136'(q2.size()), 136'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mac_dot_pipe.md
# mac_dot_pipe

Parametrised, pipelined multiply-accumulate engine; next generation of the 64-bit MAC. Adds configurable operand width, signed/unsigned mode, a pipelined multiplier, guard bits with saturation, and vector framing (last beat) with a valid/ready result handshake. It computes dot products over streamed operand pairs. Each completed sum is handed to a downstream consumer, and the accumulator restarts automatically for the next vector.

## Interface
Parameters:
- WIDTH, 64, operand width of a and b
- GUARD, 8, extra accumulator bits above 2*WIDTH
- ACC_WIDTH, 2*WIDTH+GUARD, accumulator/result width (derived, not overridden)
- MUL_STAGES, 2, multiplier pipeline registers (legal 0..4)
- SIGNED, 0, 1 = two's-complement operands and accumulator

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- in_valid  in  1  operand beat offered
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_last  in  1  beat is final element of current vector
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- accumulator  out  ACC_WIDTH  running partial sum of current vector
- out_valid  out  1  completed dot product available
- out_ready  in  1  consumer accepts result
- out_result  out  ACC_WIDTH  completed dot product
- out_overflow  out  1  saturation occurred within the vector of out_result

## Operation
- Accepted beat: product a*b enters multiplier pipe, tagged with in_last; product width 2*WIDTH, sign-extended (SIGNED=1) or zero-extended to ACC_WIDTH.
- Accumulate stage: sum = accumulator + product, computed at ACC_WIDTH+1.
  - Unsigned overflow: clamp to all-ones and set the vector's sticky overflow bit.
  - Signed overflow: clamp to max positive or min negative by the operand signs and set the sticky bit.
- Non-last beat: accumulator <= sum.
- Last beat:
  - out_result <= sum and out_overflow <= sticky | this-beat overflow.
  - out_valid <= 1; accumulator <= 0; sticky <= 0.
- Result register is one deep.
- Stall = out_valid & ~out_ready.
  - Stall freezes the entire pipeline: multiplier stages, accumulator and sticky.
  - in_ready = ~stall (combinational).
- out_valid clears on out_valid & out_ready unless a new last beat completes in the same cycle. In that case the new result loads and out_valid stays 1.
- Vector of one beat (in_last on first beat): result = a*b.
- Bubbles (in_valid=0) advance the pipe without changing accumulator.

## Timing
- Reset (synchronous) clears:
  - pipeline valids;
  - accumulator to 0, sticky to 0;
  - out_valid, out_result and out_overflow to 0.
- in_ready is 1 in the cycle after reset.
- Reset mid-vector discards all in-flight beats; no partial result is emitted.
- Latency: a beat accepted at edge t updates accumulator/out_result at edge t+MUL_STAGES, counting only unstalled edges.
- MUL_STAGES=0 matches the legacy MAC: accumulator reflects a*b at the same edge the beat is accepted.
- Throughput: one beat per cycle while not stalled.
- out_result/out_overflow are held stable while out_valid & ~out_ready.
- Reset dominates in_valid and out_ready in the same cycle.

## Structure
- Shared package mac_pkg:
  - function acc_width(WIDTH, GUARD);
  - saturation constants / functions: sat_max, sat_min per ACC_WIDTH and SIGNED.
- Sub-module mac_mul_pipe:
  - WIDTH, SIGNED and MUL_STAGES parameters;
  - carries the valid/last tag alongside the product;
  - shares the global stall enable.
- Top holds the accumulate stage, sticky overflow, result register and handshake.

## Test plan
- Reset: reset=1 for 2 cycles → accumulator=0, out_valid=0, out_result=0, in_ready=1 after release.
- Basic vector (defaults):
  - (2,3) then (7,3,last) → accumulator=6 two edges after first beat;
  - out_valid=1, out_result=27 two edges after last beat;
  - accumulator=0.
- Back-pressure: out_ready=0, vectors [(13,4),(7,3,last)] then [(3,6,last)].
  - First result 73 held; in_ready drops while stalled; second beat frozen.
  - out_ready=1 → 73 then 18, in order, none lost.
- Wide operands: A=15475927394819283748, B=12002991839102938298, last → out_result=185757430222565459333063603658598180904, out_overflow=0.
- Saturation and signed mode:
  - WIDTH=8, GUARD=0, SIGNED=0: (255,255),(255,255,last) → out_result=65535, out_overflow=1; next vector (1,1,last) → 1, out_overflow=0.
  - SIGNED=1, WIDTH=8: (-3,5),(2,4,last) → out_result=-7.
- Reset mid-vector: accept (10,5), assert reset one cycle → no out_valid, accumulator=0; then (14,2,last) → out_result=28.
